// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a song's note table in an external synchronous ROM,
// one note per tempo period, with pause, stop, loop and end-of-song pulse.
module melody_sequencer #(
    parameter int NOTE_W    = 5,
    parameter int ADDR_W    = 7,
    parameter int NUM_SONGS = 4,
    parameter int SONG_W    = 2,
    parameter int DIV_W     = 25,
    parameter int TICK_DIV  = 6000000,
    parameter int REST_CODE = 25
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     loop_en,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic [DIV_W-1:0]         tempo_div,
    output logic [SONG_W+ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0]        rom_data,
    output logic [NOTE_W-1:0]        note,
    output logic                     note_strobe,
    output logic [ADDR_W-1:0]        step,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_D = 3'd2,
        PLAY   = 3'd3,
        PAUSE  = 3'd4
    } state_t;

    localparam logic [NOTE_W-1:0] REST     = NOTE_W'(REST_CODE);
    localparam logic [DIV_W-1:0]  DEF_DIV  = DIV_W'(TICK_DIV);
    localparam logic [ADDR_W-1:0] LAST     = {ADDR_W{1'b1}};
    localparam logic [SONG_W:0]   SONG_LIM = (SONG_W+1)'(NUM_SONGS);

    state_t                    state, state_n;
    logic [SONG_W-1:0]         song_q, song_n;
    logic [DIV_W-1:0]          period_q, period_n;
    logic [DIV_W-1:0]          counter, counter_n;
    logic [ADDR_W-1:0]         step_n;
    logic [SONG_W+ADDR_W-1:0]  rom_addr_n;
    logic [NOTE_W-1:0]         note_int, note_int_n;
    logic [NOTE_W-1:0]         note_n;
    logic                      strobe_n, done_n, busy_n;
    logic [SONG_W-1:0]         song_ok;
    logic [DIV_W-1:0]          period_ok;

    assign song_ok   = ({1'b0, song_sel} >= SONG_LIM) ? '0 : song_sel;
    assign period_ok = (tempo_div >= DIV_W'(2)) ? tempo_div : DEF_DIV;

    always_comb begin
        state_n    = state;
        song_n     = song_q;
        period_n   = period_q;
        counter_n  = counter;
        step_n     = step;
        rom_addr_n = rom_addr;
        note_int_n = note_int;
        strobe_n   = 1'b0;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    song_n     = song_ok;
                    period_n   = period_ok;
                    rom_addr_n = {song_ok, {ADDR_W{1'b0}}};
                    step_n     = '0;
                    state_n    = LOAD_A;
                end
            end
            LOAD_A: state_n = LOAD_D;
            LOAD_D: begin
                note_int_n = rom_data;
                strobe_n   = 1'b1;
                counter_n  = DIV_W'(1);
                rom_addr_n = {song_q, ADDR_W'(1)};
                state_n    = PLAY;
            end
            PLAY, PAUSE: begin
                // Each edge with pause low advances the step timer, including
                // the edge that leaves PAUSE, so a pause stretches a step by
                // exactly the number of cycles it was held.
                if (pause) begin
                    state_n = PAUSE;
                end else begin
                    state_n = PLAY;
                    if (counter == period_q) begin
                        if (step == LAST && !loop_en) begin
                            note_int_n = REST;
                            done_n     = 1'b1;
                            step_n     = '0;
                            counter_n  = '0;
                            state_n    = IDLE;
                        end else begin
                            step_n     = step + ADDR_W'(1);
                            note_int_n = rom_data;
                            strobe_n   = 1'b1;
                            counter_n  = DIV_W'(1);
                            rom_addr_n = {song_q, step + ADDR_W'(2)};
                        end
                    end else begin
                        counter_n = counter + DIV_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (stop) begin
            state_n    = IDLE;
            note_int_n = REST;
            step_n     = '0;
            counter_n  = '0;
            strobe_n   = 1'b0;
            done_n     = 1'b0;
        end

        busy_n = (state_n != IDLE);
        note_n = (state_n == PAUSE) ? REST : note_int_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            song_q      <= '0;
            period_q    <= DEF_DIV;
            counter     <= '0;
            step        <= '0;
            rom_addr    <= '0;
            note_int    <= REST;
            note        <= REST;
            note_strobe <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            song_q      <= song_n;
            period_q    <= period_n;
            counter     <= counter_n;
            step        <= step_n;
            rom_addr    <= rom_addr_n;
            note_int    <= note_int_n;
            note        <= note_n;
            note_strobe <= strobe_n;
            done        <= done_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed test-plan scenarios plus randomized
// control traffic checked every cycle against a step/time reference model.
module tb_melody_sequencer;

    localparam int NOTE_W = 5, ADDR_W = 2, NUM_SONGS = 3, SONG_W = 2;
    localparam int DIV_W = 8, TICK_DIV = 4, REST_CODE = 25;
    localparam int STEPS = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n, start, stop, pause, loop_en;
    logic [SONG_W-1:0]        song_sel;
    logic [DIV_W-1:0]         tempo_div;
    logic [SONG_W+ADDR_W-1:0] rom_addr;
    logic [NOTE_W-1:0]        rom_data;
    logic [NOTE_W-1:0]        note;
    logic                     note_strobe, busy, done;
    logic [ADDR_W-1:0]        step;

    logic [NOTE_W-1:0] rom_mem [16];

    int total = 0;
    int bad = 0;

    // model state: mode 0 idle, 1 loading, 2 playing
    int m_mode, m_wait, m_song, m_period, m_step, m_elapsed, m_cur;
    bit m_paused;
    int e_note, e_strobe, e_step, e_busy, e_done;

    int kc;
    int stb_q[$];
    int nt_q[$];
    int done_at;

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    melody_sequencer #(
        .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W),
        .DIV_W(DIV_W), .TICK_DIV(TICK_DIV), .REST_CODE(REST_CODE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .loop_en(loop_en), .song_sel(song_sel), .tempo_div(tempo_div),
        .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
        .note_strobe(note_strobe), .step(step), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_wait = 0; m_song = 0; m_period = TICK_DIV;
        m_step = 0; m_elapsed = 0; m_cur = REST_CODE; m_paused = 0;
        e_note = REST_CODE; e_strobe = 0; e_step = 0; e_busy = 0; e_done = 0;
    endtask

    // Advance the reference by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        e_strobe = 0;
        e_done = 0;
        if (stop) begin
            m_mode = 0; m_step = 0; m_cur = REST_CODE; m_paused = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_song   = (int'(song_sel) >= NUM_SONGS) ? 0 : int'(song_sel);
                m_period = (int'(tempo_div) >= 2) ? int'(tempo_div) : TICK_DIV;
                m_mode = 1; m_wait = 2; m_step = 0;
            end
        end else if (m_mode == 1) begin
            m_wait--;
            if (m_wait == 0) begin
                m_mode = 2; m_paused = 0; m_elapsed = 1; e_strobe = 1;
                m_cur = rom_mem[m_song * STEPS];
            end
        end else begin
            if (pause) begin
                m_paused = 1;
            end else begin
                m_paused = 0;
                if (m_elapsed == m_period) begin
                    if (m_step == STEPS - 1 && !loop_en) begin
                        m_mode = 0; m_cur = REST_CODE; m_step = 0; e_done = 1;
                    end else begin
                        m_step = (m_step + 1) % STEPS;
                        m_cur = rom_mem[m_song * STEPS + m_step];
                        m_elapsed = 1; e_strobe = 1;
                    end
                end else begin
                    m_elapsed++;
                end
            end
        end
        e_note = (m_mode == 2 && m_paused) ? REST_CODE : m_cur;
        e_step = m_step;
        e_busy = (m_mode != 0) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        kc++;
        if (note_strobe) begin
            stb_q.push_back(kc);
            nt_q.push_back(int'(note));
        end
        if (done) done_at = kc;
        chk("note", int'(note), e_note);
        chk("strobe", int'(note_strobe), e_strobe);
        chk("step", int'(step), e_step);
        chk("busy", int'(busy), e_busy);
        chk("done", int'(done), e_done);
        if (m_mode == 1)
            chk("rom_addr_load", int'(rom_addr), m_song * STEPS);
        else if (m_mode == 2)
            chk("rom_addr_play", int'(rom_addr), m_song * STEPS + (m_step + 1) % STEPS);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic begin_song(input int s, input int t);
        kc = 0; done_at = -1;
        stb_q.delete(); nt_q.delete();
        song_sel = SONG_W'(s); tempo_div = DIV_W'(t);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic chk_strobes(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, "_s0"}, stb_q.size() > 0 ? stb_q[0] : -1, a);
        chk({tag, "_s1"}, stb_q.size() > 1 ? stb_q[1] : -1, b);
        chk({tag, "_s2"}, stb_q.size() > 2 ? stb_q[2] : -1, c);
        chk({tag, "_s3"}, stb_q.size() > 3 ? stb_q[3] : -1, d);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom_mem[i] = NOTE_W'($urandom_range(24, 0));
        rom_mem[0] = 5'd3;  rom_mem[1] = 5'd7;  rom_mem[2] = 5'd11; rom_mem[3] = 5'd2;
        rom_mem[4] = 5'd10; rom_mem[5] = 5'd13; rom_mem[6] = 5'd18; rom_mem[7] = 5'd22;
        rom_mem[8] = 5'd1;  rom_mem[9] = 5'd5;  rom_mem[10] = 5'd9; rom_mem[11] = 5'd17;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        song_sel = '0; tempo_div = '0;
        model_reset();
        kc = 0; done_at = -1;
        #22;
        chk("rst_note", int'(note), 25);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(rom_addr), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_strobe", int'(note_strobe), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // full song, no loop
        begin_song(1, 0);
        run(18);
        chk_strobes("play", 3, 7, 11, 15);
        chk("play_n0", nt_q.size() > 0 ? nt_q[0] : -1, 10);
        chk("play_n1", nt_q.size() > 1 ? nt_q[1] : -1, 13);
        chk("play_n2", nt_q.size() > 2 ? nt_q[2] : -1, 18);
        chk("play_n3", nt_q.size() > 3 ? nt_q[3] : -1, 22);
        chk("play_done_at", done_at, 19);
        chk("play_end_note", int'(note), 25);
        chk("play_end_busy", int'(busy), 0);
        run(2);

        // loop, then drop loop_en during step 2 of the second pass
        loop_en = 1'b1;
        begin_song(1, 0);
        run(18);
        chk("loop_s4", stb_q.size() > 4 ? stb_q[4] : -1, 19);
        chk("loop_step", int'(step), 0);
        chk("loop_note", int'(note), 10);
        chk("loop_nodone", done_at, -1);
        run(9);
        loop_en = 1'b0;
        run(8);
        chk("loop_done_at", done_at, 35);
        chk("loop_nstb", stb_q.size(), 8);
        run(2);

        // pause for 5 cycles at counter 2 of step 1
        begin_song(1, 0);
        run(7);
        pause = 1'b1;
        run(5);
        chk("pause_note", int'(note), 25);
        chk("pause_busy", int'(busy), 1);
        pause = 1'b0;
        run(1);
        chk("pause_resume_note", int'(note), 13);
        run(11);
        chk_strobes("pause", 3, 7, 16, 20);
        chk("pause_n2", nt_q.size() > 2 ? nt_q[2] : -1, 18);
        chk("pause_done_at", done_at, 24);
        run(2);

        // stop at counter 2 of step 2
        begin_song(1, 0);
        run(11);
        do_stop();
        chk("stop_busy", int'(busy), 0);
        chk("stop_note", int'(note), 25);
        chk("stop_step", int'(step), 0);
        run(8);
        chk("stop_nodone", done_at, -1);
        chk("stop_nstb", stb_q.size(), 3);

        // start together with stop stays idle
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        run(3);
        chk("startstop_busy", int'(busy), 0);

        // start while busy is ignored
        begin_song(1, 0);
        run(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        run(14);
        chk_strobes("rebusy", 3, 7, 11, 15);
        chk("rebusy_done_at", done_at, 19);
        chk("rebusy_nstb", stb_q.size(), 4);
        run(2);

        // tempo_div below 2 falls back to the default period
        begin_song(1, 1);
        run(6);
        chk("tempo1_s0", stb_q.size() > 0 ? stb_q[0] : -1, 3);
        chk("tempo1_s1", stb_q.size() > 1 ? stb_q[1] : -1, 7);
        do_stop();

        begin_song(1, 3);
        run(14);
        chk_strobes("tempo3", 3, 6, 9, 12);
        chk("tempo3_done_at", done_at, 15);
        run(2);

        // out-of-range song selects song 0
        begin_song(3, 0);
        chk("sel3_addr_load", int'(rom_addr), 0);
        run(2);
        chk("sel3_note", int'(note), 3);
        chk("sel3_addr_play", int'(rom_addr), 1);
        run(3);

        // asynchronous reset mid-song
        begin_song(2, 0);
        run(8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_note", int'(note), 25);
        chk("arst_busy", int'(busy), 0);
        chk("arst_step", int'(step), 0);
        chk("arst_addr", int'(rom_addr), 0);
        chk("arst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // randomized control traffic
        for (int i = 0; i < 4000; i++) begin
            start    = ($urandom_range(7, 0) == 0);
            stop     = ($urandom_range(79, 0) == 0);
            if ($urandom_range(9, 0) == 0) pause = ~pause;
            if ($urandom_range(19, 0) == 0) loop_en = ~loop_en;
            song_sel  = SONG_W'($urandom_range(3, 0));
            tempo_div = DIV_W'($urandom_range(5, 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Parametrised melody player for the music engine, replacing the hard-coded per-song melody FSMs.
- Steps through a note table in an external synchronous ROM that holds NUM_SONGS songs of 2^ADDR_W steps each.
- Emits one NOTE_W-bit note code per step, for the downstream tone generator.
- Adds song select, runtime tempo, start/stop/pause, loop mode and an end-of-song pulse.

Parameters:
- NOTE_W, 5: note code width.
- ADDR_W, 7: step index width; song length is 2^ADDR_W steps.
- NUM_SONGS, 4: number of songs in the ROM.
- SONG_W, 2: song index width; must be at least 1 and satisfy 2^SONG_W >= NUM_SONGS.
- DIV_W, 25: tempo counter width.
- TICK_DIV, 6000000: default step length in clk cycles.
- REST_CODE, 25: note code meaning silence.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  single-cycle request to start playback.
- stop  in  1  abort playback; highest priority.
- pause  in  1  level; holds playback while high.
- loop_en  in  1  level; sampled at end of the last step.
- song_sel  in  SONG_W  song index; latched on start.
- tempo_div  in  DIV_W  step length in cycles; latched on start.
- rom_addr  out  SONG_W+ADDR_W  registered ROM address {song, step}.
- rom_data  in  NOTE_W  ROM data for the rom_addr of the previous cycle.
- note  out  NOTE_W  current note code.
- note_strobe  out  1  one-cycle pulse when note loads a new step.
- step  out  ADDR_W  current step index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at natural end of song.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, note=REST_CODE, note_strobe=0, done=0, busy=0, step=0, rom_addr=0, counter=0.
- States: IDLE, LOAD_A, LOAD_D, PLAY, PAUSE. All outputs are registered.
- Period: period = tempo_div if tempo_div>=2, else TICK_DIV.
- Song index: a song_sel value >= NUM_SONGS selects song 0.
- IDLE, start=1:
  - Latch song and period.
  - rom_addr<={song,0}, step<=0.
  - Go to LOAD_A.
- IDLE, start=0: no change; note stays REST_CODE.
- LOAD_A: go to LOAD_D after one cycle; this is ROM latency.
- LOAD_D:
  - note<=rom_data, note_strobe<=1.
  - counter<=1, rom_addr<={song,1}.
  - Go to PLAY. The first strobe occurs 3 cycles after the start edge.
- PLAY, counter increments each cycle. At counter==period, the step ends:
  - If step==2^ADDR_W-1 and loop_en=0: note<=REST_CODE, done<=1, step<=0, go to IDLE.
  - Otherwise: step<=step+1 (wraps to 0); note<=rom_data (the prefetched next step); note_strobe<=1; counter<=1; rom_addr<={song, step+2}, modulo 2^ADDR_W.
  - Every step lasts exactly period cycles, strobe to strobe.
- Prefetch: the rom_addr for step n+1 is valid at least 2 cycles before it is used, which requires period>=2.
- PAUSE, entered from PLAY when pause=1:
  - counter, step and rom_addr freeze; the internal note is held.
  - The note output reads REST_CODE while paused.
  - pause=0 returns to PLAY next cycle; counting resumes from the frozen value.
- pause asserted in LOAD_A or LOAD_D: takes effect after entry to PLAY.
- stop=1 in any state:
  - Next state IDLE, note=REST_CODE, busy=0, step=0.
  - No done, no strobe.
  - stop beats start and pause in the same cycle.
- start while busy: ignored; no restart.
- rst_n low mid-song: immediate return to the reset values; no done.

Test Plan:
1. Reset: rst_n=0 -> note=25, busy=0, done=0, rom_addr=0, step=0; asynchronous assertion mid-song clears immediately.
2. Setup: ADDR_W=2, TICK_DIV=4, song 1 = {10,13,18,22}, tempo_div=0, loop_en=0. Pulse start -> strobes at start+3, +7, +11, +15 with note 10,13,18,22; done at +19 with note=25 and busy=0.
3. Same setup with loop_en=1 -> at +19 step=0, note=10, no done. Drop loop_en during step 2 of pass 2 -> done after step 3 of pass 2.
4. Pause asserted for 5 cycles at counter=2 of step 1 -> note=25 while paused; step 1 lasts 4+5=9 cycles, then resumes 13; following steps last 4 cycles.
5. stop at counter=2 of step 2 -> IDLE next cycle, note=25, no done. start and stop in the same cycle -> remains IDLE. start while busy -> ignored, step sequence unchanged.
6. Tempo and song select:
   - tempo_div=1 -> step length 4 (TICK_DIV).
   - tempo_div=3 -> step length 3.
   - song_sel=3 with NUM_SONGS=3 -> plays song 0 and rom_addr upper bits are 0.
